mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_array_sp.sv | 21 ++
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and default constants for the MAR/MDR memory responder.
package mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 9;
    localparam int WAIT_MAX   = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/mem_responder_if.sv
// MAR/MDR memory port between the control unit (master) and mem_responder (slave).
interface mem_responder_if #(
    parameter int DATA_W = mem_pkg::MEM_DATA_W
);
    logic [31:0]       mar_addr;
    logic [DATA_W-1:0] mdr_wdata;
    logic              rd_req;
    logic              wr_req;
    logic [DATA_W-1:0] mdata_out;
    logic              done;
    logic              busy;
    logic              err;

    modport master (
        output mar_addr, mdr_wdata, rd_req, wr_req,
        input  mdata_out, done, busy, err
    );

    modport slave (
        input  mar_addr, mdr_wdata, rd_req, wr_req,
        output mdata_out, done, busy, err
    );
endinterface

// File: rtl/mem_array_sp.sv
// Single-port synchronous RAM; read data is registered and holds between reads.
module mem_array_sp #(
    parameter int DATA_W = mem_pkg::MEM_DATA_W,
    parameter int ADDR_W = mem_pkg::MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for the MAR/MDR port.
// Optional feature: define MEM_BOUNDS_CHECK_EN to reject addresses with upper bits set.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = MEM_DATA_W,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              oob_q;
    logic              err_q;
    logic              out_zero;
    logic [DATA_W-1:0] rdata;

    logic              accept;
    logic              commit;
    logic              in_oob;
    op_e               in_op;
    op_e               c_op;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_oob;

`ifdef MEM_BOUNDS_CHECK_EN
    assign in_oob = |bus.mar_addr[31:ADDR_W];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.mar_addr[31:ADDR_W];
    assign in_oob = 1'b0;
`endif

    assign accept = (state == S_IDLE) && (bus.rd_req ^ bus.wr_req);
    assign in_op  = bus.wr_req ? OP_WR : OP_RD;

    // With zero wait states the access commits on the accept edge, straight from the port.
    assign commit  = ((state == S_WAIT) && (cnt == CNT_W'(1))) ||
                     (accept && (WAIT_CYCLES == 0));
    assign c_op    = (state == S_IDLE) ? in_op : op_q;
    assign c_addr  = (state == S_IDLE) ? bus.mar_addr[ADDR_W-1:0] : addr_q;
    assign c_wdata = (state == S_IDLE) ? bus.mdr_wdata : wdata_q;
    assign c_oob   = (state == S_IDLE) ? in_oob : oob_q;

    mem_array_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (commit && (c_op == OP_WR) && !c_oob),
        .re    (commit && (c_op == OP_RD) && !c_oob),
        .addr  (c_addr),
        .wdata (c_wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= in_op;
            addr_q  <= bus.mar_addr[ADDR_W-1:0];
            wdata_q <= bus.mdr_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            oob_q    <= 1'b0;
            err_q    <= 1'b0;
            out_zero <= 1'b1;
        end else begin
            err_q <= ((state == S_IDLE) && bus.rd_req && bus.wr_req) || (commit && c_oob);
            // RAM output is masked until a real read lands, so reset and rejected reads read as zero.
            if (commit && (c_op == OP_RD))
                out_zero <= c_oob;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt   <= CNT_W'(WAIT_CYCLES);
                        oob_q <= in_oob;
                        state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.done      = (state == S_RESP);
    assign bus.busy      = (state != S_IDLE);
    assign bus.err       = err_q;
    assign bus.mdata_out = out_zero ? '0 : rdata;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_mem_responder;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(32)) bus2 ();
    mem_responder_if #(.DATA_W(32)) bus0 ();

    mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        done;
        logic        busy;
        logic        err;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic done, input logic busy,
                       input logic err, input logic [31:0] data);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.done = done; v.busy = busy; v.err = err; v.data = data;
        vecs.push_back(v);
    endtask

    task automatic drive2(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bus2.rd_req = rd; bus2.wr_req = wr; bus2.mar_addr = addr; bus2.mdr_wdata = wdata;
    endtask

    // Issue one request on the WAIT_CYCLES=2 instance and wait (bounded) for done.
    task automatic xact2(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input string name);
        logic got;
        got = 1'b0;
        drive2(rd, wr, addr, wdata);
        @(posedge clk); #1;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            if (bus2.done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({name, ".done"}, {31'b0, got}, 32'd1);
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] V9 = 32'h11111111;
    localparam logic [31:0] V0 = 32'hCAFEF00D;
`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic        OOB_ERR  = 1'b1;
    localparam logic [31:0] OOB_DATA = 32'h0;
`else
    localparam logic        OOB_ERR  = 1'b0;
    localparam logic [31:0] OOB_DATA = V0;
`endif

    initial begin
        // Entry i: inputs in cycle i, expected outputs in cycle i+1.
        add(0, 1, 5,      DB, 0, 1, 0, 0);
        add(0, 0, 0,      0,  0, 1, 0, 0);
        add(0, 0, 0,      0,  1, 1, 0, 0);
        add(0, 0, 0,      0,  0, 0, 0, 0);
        add(1, 0, 5,      0,  0, 1, 0, 0);
        add(0, 0, 0,      0,  0, 1, 0, 0);
        add(0, 0, 0,      0,  1, 1, 0, DB);
        add(0, 0, 0,      0,  0, 0, 0, DB);
        add(0, 1, 9,      V9, 0, 1, 0, DB);
        add(1, 0, 5,      0,  0, 1, 0, DB);
        add(1, 1, 5,      0,  1, 1, 0, DB);
        add(1, 0, 9,      0,  0, 0, 0, DB);
        add(0, 0, 0,      0,  0, 0, 0, DB);
        add(1, 0, 9,      0,  0, 1, 0, DB);
        add(0, 0, 0,      0,  0, 1, 0, DB);
        add(0, 0, 0,      0,  1, 1, 0, V9);
        add(0, 0, 0,      0,  0, 0, 0, V9);
        add(1, 1, 5,      0,  0, 0, 1, V9);
        add(0, 0, 0,      0,  0, 0, 0, V9);
        add(1, 0, 5,      0,  0, 1, 0, V9);
        add(0, 0, 0,      0,  0, 1, 0, V9);
        add(0, 0, 0,      0,  1, 1, 0, DB);
        add(0, 0, 0,      0,  0, 0, 0, DB);
        add(0, 1, 0,      V0, 0, 1, 0, DB);
        add(0, 0, 0,      0,  0, 1, 0, DB);
        add(0, 0, 0,      0,  1, 1, 0, DB);
        add(0, 0, 0,      0,  0, 0, 0, DB);
        add(1, 0, 32'h200, 0, 0, 1, 0, DB);
        add(0, 0, 0,      0,  0, 1, 0, DB);
        add(0, 0, 0,      0,  1, 1, OOB_ERR, OOB_DATA);
        add(0, 0, 0,      0,  0, 0, 0, OOB_DATA);

        reset = 1'b1;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        bus0.rd_req = 1'b0; bus0.wr_req = 1'b0; bus0.mar_addr = 32'h0; bus0.mdr_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst2.done", {31'b0, bus2.done}, 0);
        chk("rst2.busy", {31'b0, bus2.busy}, 0);
        chk("rst2.err",  {31'b0, bus2.err},  0);
        chk("rst2.data", bus2.mdata_out,     0);
        chk("rst0.done", {31'b0, bus0.done}, 0);
        chk("rst0.data", bus0.mdata_out,     0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive2(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.done", i), {31'b0, bus2.done}, {31'b0, vecs[i].done});
            chk($sformatf("vec%0d.busy", i), {31'b0, bus2.busy}, {31'b0, vecs[i].busy});
            chk($sformatf("vec%0d.err", i),  {31'b0, bus2.err},  {31'b0, vecs[i].err});
            chk($sformatf("vec%0d.data", i), bus2.mdata_out,     vecs[i].data);
        end
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;

        // Reset during WAIT discards the uncommitted write.
        xact2(1'b0, 1'b1, 32'd7, 32'h01020304, "pre_wr7");
        @(posedge clk); #1;
        drive2(1'b0, 1'b1, 32'd7, 32'hAAAA5555);
        @(posedge clk); #1;
        drive2(1'b0, 1'b0, 32'h0, 32'h0);
        chk("midrst.busy_before", {31'b0, bus2.busy}, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst.done", {31'b0, bus2.done}, 0);
        chk("midrst.busy", {31'b0, bus2.busy}, 0);
        chk("midrst.err",  {31'b0, bus2.err},  0);
        chk("midrst.data", bus2.mdata_out,     0);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst.no_late_done", {31'b0, bus2.done}, 0);
        xact2(1'b1, 1'b0, 32'd7, 32'h0, "rd7");
        chk("rd7.data", bus2.mdata_out, 32'h01020304);
        @(posedge clk); #1;

        // Zero wait states: done in the cycle right after the request.
        bus0.wr_req = 1'b1; bus0.mar_addr = 32'd0; bus0.mdr_wdata = 32'h12345678;
        @(posedge clk); #1;
        bus0.wr_req = 1'b0; bus0.mdr_wdata = 32'h0;
        chk("w0wr.done", {31'b0, bus0.done}, 1);
        chk("w0wr.busy", {31'b0, bus0.busy}, 1);
        chk("w0wr.data", bus0.mdata_out,     0);
        @(posedge clk); #1;
        chk("w0wr.idle", {31'b0, bus0.done}, 0);
        bus0.rd_req = 1'b1;
        @(posedge clk); #1;
        bus0.rd_req = 1'b0;
        chk("w0rd.done", {31'b0, bus0.done}, 1);
        chk("w0rd.busy", {31'b0, bus0.busy}, 1);
        chk("w0rd.data", bus0.mdata_out,     32'h12345678);
        @(posedge clk); #1;
        chk("w0rd.idle_done", {31'b0, bus0.done}, 0);
        chk("w0rd.idle_busy", {31'b0, bus0.busy}, 0);
        chk("w0rd.hold", bus0.mdata_out, 32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
